// File: rtl/tc_stack_pkg.sv
// Shared types and constants for the TC RAM stack controller.
package tc_stack_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } state_e;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_DEPTH = 256;

   // One extra bit so the count can reach DEPTH without wrapping.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/tc_stack_ctrl.sv
// Stack controller in front of the 256x8 TC RAM: turns push/pop strobes into
// RAM traffic, tracks the stack pointer and registers the popped data.
module tc_stack_ctrl
   import tc_stack_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned WIDTH = DEF_WIDTH,
   localparam int unsigned CW = cnt_w(DEPTH)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             pop_valid,
   output logic             busy,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             err_overflow,
   output logic             err_underflow,
   input  logic             clr_err,
   output logic [7:0]       ram_address,
   output logic             ram_load,
   output logic             ram_save,
   output logic [WIDTH-1:0] ram_in,
   input  logic [WIDTH-1:0] ram_out
);

   state_e           state_q, state_d;
   logic [CW-1:0]    sp_q, sp_d;
   logic [WIDTH-1:0] pop_data_q, pop_data_d;
   logic             pop_valid_q, pop_valid_d;
   logic             err_ovf_q, err_ovf_d;
   logic             err_unf_q, err_unf_d;

   logic             pop_go, push_go, pop_unf, push_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sp_q        <= '0;
         pop_data_q  <= '0;
         pop_valid_q <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_unf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sp_q        <= sp_d;
         pop_data_q  <= pop_data_d;
         pop_valid_q <= pop_valid_d;
         err_ovf_q   <= err_ovf_d;
         err_unf_q   <= err_unf_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sp_d        = sp_q;
      pop_data_d  = pop_data_q;
      pop_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pop_go) begin
               sp_d    = sp_q - CW'(1);
               state_d = RD_WAIT;
            end else if (push_go) begin
               sp_d = sp_q + CW'(1);
            end
         end
         RD_WAIT: begin
            pop_data_d  = ram_out;
            pop_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A new error in the same cycle as clr_err still leaves the flag set.
      err_ovf_d = (err_ovf_q & ~clr_err) | push_ovf;
      err_unf_d = (err_unf_q & ~clr_err) | pop_unf;
   end

   always_comb begin
      pop_go      = 1'b0;
      push_go     = 1'b0;
      pop_unf     = 1'b0;
      push_ovf    = 1'b0;
      ram_load    = 1'b0;
      ram_save    = 1'b0;
      ram_address = '0;
      ram_in      = '0;
      if (state_q == IDLE) begin
         if (pop) begin
            pop_go  = !empty;
            pop_unf = empty;
         end else if (push) begin
            push_go  = !full;
            push_ovf = full;
         end
      end
      if (!rst) begin
         if (pop_go) begin
            ram_load    = 1'b1;
            ram_address = 8'(sp_q - CW'(1));
         end else if (push_go) begin
            ram_save    = 1'b1;
            ram_address = 8'(sp_q);
            ram_in      = push_data;
         end
      end
   end

   assign pop_data      = pop_data_q;
   assign pop_valid     = pop_valid_q;
   assign busy          = (state_q == RD_WAIT);
   assign count         = sp_q;
   assign empty         = (sp_q == '0);
   assign full          = (sp_q == CW'(DEPTH));
   assign err_overflow  = err_ovf_q;
   assign err_underflow = err_unf_q;

endmodule

// File: doc/tc_stack_ctrl.md
# tc_stack_ctrl

Stack controller placed directly upstream of the 256×8 TC RAM. It converts single-cycle push/pop strobes into RAM address/load/save traffic and maintains the stack pointer. It also registers the RAM's tri-stated read data into a clean pop result and reports occupancy and error status to the CPU datapath.

## Interface

- DEPTH, 256: stack entries. Power of two, 2..256; occupies RAM addresses 0..DEPTH-1.
- WIDTH, 8: data width; must match the RAM.
- clk  in  1  clock. All state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- push  in  1  push strobe, one cycle per operation.
- push_data  in  WIDTH  value to push, sampled with push.
- pop  in  1  pop strobe, one cycle per operation.
- pop_data  out  WIDTH  popped value, held until the next pop completes.
- pop_valid  out  1  one-cycle pulse: pop_data updated.
- busy  out  1  pop in flight; strobes ignored.
- count  out  $clog2(DEPTH)+1  entries currently stored.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- err_overflow  out  1  sticky: push while full.
- err_underflow  out  1  sticky: pop while empty.
- clr_err  in  1  clears both sticky error flags.
- ram_address  out  8  to RAM address.
- ram_load  out  1  to RAM load.
- ram_save  out  1  to RAM save.
- ram_in  out  WIDTH  to RAM in.
- ram_out  in  WIDTH  from RAM out. Valid only in the cycle after ram_load; Z otherwise.

## Operation

- Stack pointer sp = count; points at the next free slot. Grows upward from address 0.
- FSM states: IDLE and RD_WAIT.
- IDLE, pop && !empty:
  - ram_load=1, ram_address=sp-1.
  - sp decrements.
  - Next state RD_WAIT.
- IDLE, pop && empty:
  - No RAM access.
  - err_underflow set.
  - Stay in IDLE.
- IDLE, push && !pop && !full:
  - ram_save=1, ram_address=sp, ram_in=push_data.
  - sp increments.
  - Stay in IDLE.
- IDLE, push && full:
  - Push dropped.
  - err_overflow set.
- IDLE, push && pop in the same cycle: pop wins, push is dropped silently with no flag, and the caller retries. If the stack is empty, the pop underflows and the push is still dropped.
- RD_WAIT:
  - Capture ram_out into pop_data at the end of the cycle; pop_valid pulses the following cycle.
  - Return to IDLE unconditionally.
  - busy=1. push/pop strobes ignored, no flags.
- ram_load, ram_save, ram_address and ram_in are combinational decodes of state and strobes.
  - Never high together.
  - Both low in RD_WAIT and during rst.
  - ram_address=0 and ram_in=0 when idle.
- Width rules:
  - sp is $clog2(DEPTH)+1 bits, so count reaches DEPTH without wrap.
  - ram_address is zero-extended to 8 bits.
  - No wrap-around of sp: full/empty checks make increment/decrement beyond bounds impossible.
- Error flags:
  - clr_err clears both flags.
  - If clr_err coincides with a new error, set wins.
- Reset values: sp=0, state=IDLE, pop_data=0, pop_valid=0, busy=0, empty=1, full=0, both error flags 0.
- Reset mid-pop: rst in RD_WAIT aborts the pop. No pop_valid; the decremented sp is discarded with sp=0. RAM contents are not cleared by this block.

## Timing

- Push: strobe in cycle N; the RAM commits on the negedge within cycle N. count updates at the posedge ending N.
- Pop: strobe in cycle N, with ram_load high in N. RAM output is valid in N+1; pop_data is registered at the end of N+1. pop_valid is high in N+2.
- busy is high in cycle N+1 only. A new strobe is accepted in N+2, so pop throughput is one per 2 cycles and push throughput is one per cycle.
- A push in cycle N followed by a pop in N+1 returns the pushed value. The RAM write completes at the negedge of N, before the read in N+1.
- empty, full and count are registered and reflect all operations accepted up to the previous edge.

## Structure

- Package tc_stack_pkg holds:
  - the state enum (IDLE, RD_WAIT);
  - the default WIDTH and DEPTH constants;
  - the count width as a function of DEPTH.
- No sub-module required: single FSM plus pointer register. The RAM is instantiated by the parent, not inside this block.

## Test plan

- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles, then pop three times spaced 2 cycles apart. Required: pop_data 0x33, 0x22, 0x11, each with pop_valid at N+2, and count ending at 0 with empty=1.
- With DEPTH=4: push 4 values, then push 0x55. Required: full=1, err_overflow=1, count=4, and a subsequent pop returns the 4th value, not 0x55.
- Pop when empty. Required: err_underflow=1, no ram_load, no pop_valid. Then clr_err: both flags return to 0.
- push 0xAA and pop strobed in the same cycle with count=2. Required: pop returns the previous top, count=1, and 0xAA is not stored.
- Push 0x7E, then pop and push strobed in back-to-back cycles. Required: the push during busy is ignored, with count and flags unchanged.
- Assert rst during RD_WAIT. Required: no pop_valid, count=0, empty=1, and outputs at their reset values on the next cycle.
